// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_pkg
//  Description : Shared definitions for the execute stage: ALU operation
//                codes, FSM state encodings, the multiplier iteration bound,
//                the captured-control bundle and the single-cycle ALU
//                evaluation function.
//  Revision    : 1.0 - initial release
// ============================================================================
package ex_pkg;

    // ALU operation codes (low four bits of the opcode field)
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOR  = 4'h5;
    localparam logic [3:0] OP_SLT  = 4'h6;
    localparam logic [3:0] OP_SLTU = 4'h7;
    localparam logic [3:0] OP_SLL  = 4'h8;
    localparam logic [3:0] OP_SRL  = 4'h9;
    localparam logic [3:0] OP_SRA  = 4'hA;
    localparam logic [3:0] OP_MUL  = 4'hF;

    // Execute-stage FSM encodings
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Counter value of the last shift-add iteration (32 iterations total)
    localparam logic [4:0] MUL_LAST_ITER = 5'd31;

    // Memory-stage controls held for the duration of a multiply
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
    } ex_ctrl_t;

    // Single-cycle ALU. MUL and the unassigned codes B..E return 0; the
    // multiply result comes from the iterative multiplier instead.
    function automatic logic [31:0] alu_eval(
        input logic [3:0]  op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [31:0] res;
        res = 32'h0;
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOR:  res = ~(a | b);
            OP_SLT:  res = {31'b0, ($signed(a) < $signed(b))};
            OP_SLTU: res = {31'b0, (a < b)};
            OP_SLL:  res = a << b[4:0];
            OP_SRL:  res = a >> b[4:0];
            OP_SRA:  res = 32'($signed(a) >>> b[4:0]);
            default: res = 32'h0;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_mul32.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mul32
//  Description : Iterative 32x32 shift-add multiplier keeping the low 32 bits
//                of the product. One partial product is accumulated per
//                enabled clock; 32 iterations complete a multiply.
//  Ports       : clk_i   - clock
//                rst_ni  - asynchronous active-low reset
//                start_i - load operands, clear accumulator and counter
//                en_i    - perform one iteration this edge
//                a_i/b_i - multiplicand / multiplier
//                prod_o  - accumulator value including the current iteration
//                done_o  - current enabled iteration is the last one
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mul32
    import ex_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        en_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] prod_o,
    output logic        done_o
);

    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] acc_next;

    // Multiplicand shifts left, multiplier shifts right: bit 0 of the
    // multiplier always selects whether the aligned multiplicand is added.
    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : 32'h0);

    // The result is exposed combinationally so the final iteration can be
    // registered straight into the pipeline register on the same edge.
    assign prod_o = acc_next;
    assign done_o = en_i && (cnt_q == MUL_LAST_ITER);

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (start_i) begin
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = 32'h0;
            cnt_d    = 5'd0;
        end else if (en_i) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            acc_d    = acc_next;
            cnt_d    = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mcand_q  <= 32'h0;
            mplier_q <= 32'h0;
            acc_q    <= 32'h0;
            cnt_q    <= 5'd0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage
//  Description : Pipeline execute stage. Forwards operands from the EX and
//                MEM stages, evaluates single-cycle ALU ops with latency 1,
//                and runs MUL on an iterative multiplier while stalling ID.
//  Ports       : Clk, Rst_n          - clock, asynchronous active-low reset
//                ID*                 - decoded instruction from ID
//                MEM*                - memory-stage writeback (forwarding)
//                EX*                 - registered results to memory stage
//                Stall               - ID must hold its outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_stage
    import ex_pkg::*;
#(
    parameter int ALU_OP_W = 4
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                IDValid,
    input  logic                IDRegWrite,
    input  logic                IDMemRead,
    input  logic                IDMemWrite,
    input  logic                IDALUSrc,
    input  logic [4:0]          IDRs,
    input  logic [4:0]          IDRt,
    input  logic [4:0]          IDRd,
    input  logic [31:0]         IDA,
    input  logic [31:0]         IDB,
    input  logic [31:0]         IDImm,
    input  logic [ALU_OP_W-1:0] IDALUOp,
    input  logic [4:0]          MEMRd,
    input  logic [31:0]         MEMData,
    input  logic                MEMRegWrite,
    output logic                EXRegWrite,
    output logic                EXMemRead,
    output logic                EXMemWrite,
    output logic [4:0]          EXRd,
    output logic [31:0]         EXData,
    output logic [31:0]         EXALUData,
    output logic                Stall
);

    // ------------------------------------------------------------------
    // State and pipeline registers
    // ------------------------------------------------------------------
    logic [0:0]  state_q, state_d;
    ex_ctrl_t    cap_ctrl_q, cap_ctrl_d;
    logic [31:0] cap_store_q, cap_store_d;

    logic        ex_rw_q, ex_rw_d;
    logic        ex_mr_q, ex_mr_d;
    logic        ex_mw_q, ex_mw_d;
    logic [4:0]  ex_rd_q, ex_rd_d;
    logic [31:0] ex_data_q, ex_data_d;
    logic [31:0] ex_alu_q, ex_alu_d;

    // ------------------------------------------------------------------
    // Opcode decode. The opcode is zero-extended by four bits so the low
    // nibble and the "upper bits are zero" test are well formed for any
    // ALU_OP_W; codes above 4'hF behave like the unassigned codes.
    // ------------------------------------------------------------------
    logic [ALU_OP_W+3:0] op_wide;
    logic [3:0]          op4;
    logic                op_hi_zero;
    logic                is_mul;

    assign op_wide    = {4'b0, IDALUOp};
    assign op4        = op_wide[3:0];
    assign op_hi_zero = (op_wide[ALU_OP_W+3:4] == '0);
    assign is_mul     = op_hi_zero && (op4 == OP_MUL);

    // ------------------------------------------------------------------
    // Forwarding. A load in EX has no data yet, so it is skipped and the
    // older MEM-stage value (if any) is used instead.
    // ------------------------------------------------------------------
    logic        ex_fwd_ok;
    logic [31:0] fwd_a, fwd_b, alu_b, alu_res;

    assign ex_fwd_ok = ex_rw_q && !ex_mr_q && (ex_rd_q != 5'd0);

    always_comb begin
        fwd_a = IDA;
        if (ex_fwd_ok && (ex_rd_q == IDRs)) begin
            fwd_a = ex_alu_q;
        end else if (MEMRegWrite && (MEMRd != 5'd0) && (MEMRd == IDRs)) begin
            fwd_a = MEMData;
        end
    end

    always_comb begin
        fwd_b = IDB;
        if (ex_fwd_ok && (ex_rd_q == IDRt)) begin
            fwd_b = ex_alu_q;
        end else if (MEMRegWrite && (MEMRd != 5'd0) && (MEMRd == IDRt)) begin
            fwd_b = MEMData;
        end
    end

    assign alu_b   = IDALUSrc ? IDImm : fwd_b;
    assign alu_res = op_hi_zero ? alu_eval(op4, fwd_a, alu_b) : 32'h0;

    // ------------------------------------------------------------------
    // Multiplier
    // ------------------------------------------------------------------
    logic        mul_start;
    logic        mul_en;
    logic        mul_done;
    logic [31:0] mul_prod;

    assign mul_en = (state_q == ST_BUSY);

    seq_mul32 u_mul (
        .clk_i   (Clk),
        .rst_ni  (Rst_n),
        .start_i (mul_start),
        .en_i    (mul_en),
        .a_i     (fwd_a),
        .b_i     (alu_b),
        .prod_o  (mul_prod),
        .done_o  (mul_done)
    );

    // Stall is released on the final iteration so that ID advances on the
    // same edge that retires the product. Gated by reset so a held MUL
    // instruction does not assert Stall while the stage is in reset.
    assign Stall = Rst_n &&
                   (((state_q == ST_IDLE) && IDValid && is_mul) ||
                    ((state_q == ST_BUSY) && !mul_done));

    // ------------------------------------------------------------------
    // Next-state / next-output logic. Default is a bubble.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cap_ctrl_d  = cap_ctrl_q;
        cap_store_d = cap_store_q;
        mul_start   = 1'b0;
        ex_rw_d     = 1'b0;
        ex_mr_d     = 1'b0;
        ex_mw_d     = 1'b0;
        ex_rd_d     = 5'd0;
        ex_data_d   = 32'h0;
        ex_alu_d    = 32'h0;

        case (state_q)
            ST_IDLE: begin
                if (IDValid) begin
                    if (is_mul) begin
                        mul_start   = 1'b1;
                        cap_ctrl_d  = '{reg_write: IDRegWrite,
                                        mem_read:  IDMemRead,
                                        mem_write: IDMemWrite};
                        cap_store_d = fwd_b;
                        state_d     = ST_BUSY;
                    end else begin
                        ex_rw_d   = IDRegWrite;
                        ex_mr_d   = IDMemRead;
                        ex_mw_d   = IDMemWrite;
                        ex_rd_d   = IDRd;
                        ex_data_d = fwd_b;
                        ex_alu_d  = alu_res;
                    end
                end
            end
            ST_BUSY: begin
                // ID inputs other than IDRd are ignored while busy; ID is
                // still holding the MUL, so IDRd is its destination.
                if (mul_done) begin
                    ex_rw_d   = cap_ctrl_q.reg_write;
                    ex_mr_d   = cap_ctrl_q.mem_read;
                    ex_mw_d   = cap_ctrl_q.mem_write;
                    ex_rd_d   = IDRd;
                    ex_data_d = cap_store_q;
                    ex_alu_d  = mul_prod;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= ST_IDLE;
            cap_ctrl_q  <= '0;
            cap_store_q <= 32'h0;
            ex_rw_q     <= 1'b0;
            ex_mr_q     <= 1'b0;
            ex_mw_q     <= 1'b0;
            ex_rd_q     <= 5'd0;
            ex_data_q   <= 32'h0;
            ex_alu_q    <= 32'h0;
        end else begin
            state_q     <= state_d;
            cap_ctrl_q  <= cap_ctrl_d;
            cap_store_q <= cap_store_d;
            ex_rw_q     <= ex_rw_d;
            ex_mr_q     <= ex_mr_d;
            ex_mw_q     <= ex_mw_d;
            ex_rd_q     <= ex_rd_d;
            ex_data_q   <= ex_data_d;
            ex_alu_q    <= ex_alu_d;
        end
    end

    assign EXRegWrite = ex_rw_q;
    assign EXMemRead  = ex_mr_q;
    assign EXMemWrite = ex_mw_q;
    assign EXRd       = ex_rd_q;
    assign EXData     = ex_data_q;
    assign EXALUData  = ex_alu_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_stage
//  Description : Self-checking bench for ex_stage: directed scenarios plus
//                randomized instruction streams compared cycle by cycle
//                against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b1;
    logic        IDValid = 1'b0, IDRegWrite = 1'b0, IDMemRead = 1'b0;
    logic        IDMemWrite = 1'b0, IDALUSrc = 1'b0;
    logic [4:0]  IDRs = '0, IDRt = '0, IDRd = '0;
    logic [31:0] IDA = '0, IDB = '0, IDImm = '0;
    logic [3:0]  IDALUOp = '0;
    logic [4:0]  MEMRd = '0;
    logic [31:0] MEMData = '0;
    logic        MEMRegWrite = 1'b0;
    logic        EXRegWrite, EXMemRead, EXMemWrite;
    logic [4:0]  EXRd;
    logic [31:0] EXData, EXALUData;
    logic        Stall;

    always #5 Clk = ~Clk;

    ex_stage #(.ALU_OP_W(4)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .IDValid(IDValid), .IDRegWrite(IDRegWrite),
        .IDMemRead(IDMemRead), .IDMemWrite(IDMemWrite), .IDALUSrc(IDALUSrc),
        .IDRs(IDRs), .IDRt(IDRt), .IDRd(IDRd), .IDA(IDA), .IDB(IDB),
        .IDImm(IDImm), .IDALUOp(IDALUOp), .MEMRd(MEMRd), .MEMData(MEMData),
        .MEMRegWrite(MEMRegWrite), .EXRegWrite(EXRegWrite),
        .EXMemRead(EXMemRead), .EXMemWrite(EXMemWrite), .EXRd(EXRd),
        .EXData(EXData), .EXALUData(EXALUData), .Stall(Stall)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- ID instruction bundle ----------------
    typedef struct packed {
        logic        valid, rw, mr, mw, alusrc;
        logic [4:0]  rs, rt, rd;
        logic [31:0] a, b, imm;
        logic [3:0]  op;
    } id_t;

    task automatic apply(input id_t s);
        IDValid = s.valid; IDRegWrite = s.rw; IDMemRead = s.mr;
        IDMemWrite = s.mw; IDALUSrc = s.alusrc;
        IDRs = s.rs; IDRt = s.rt; IDRd = s.rd;
        IDA = s.a; IDB = s.b; IDImm = s.imm; IDALUOp = s.op;
    endtask

    task automatic set_mem(input logic rw, input logic [4:0] rd, input logic [31:0] d);
        MEMRegWrite = rw; MEMRd = rd; MEMData = d;
    endtask

    function automatic id_t rnd_id();
        id_t s;
        s.valid  = ($urandom % 4) != 0;
        s.rw     = $urandom % 2;
        s.mr     = ($urandom % 4) == 0;
        s.mw     = ($urandom % 4) == 0;
        s.alusrc = $urandom % 2;
        s.rs     = 5'($urandom % 8);
        s.rt     = 5'($urandom % 8);
        s.rd     = 5'($urandom % 8);
        s.a      = ($urandom % 2) ? $urandom : 32'($urandom % 16) - 32'd8;
        s.b      = ($urandom % 2) ? $urandom : 32'($urandom % 40);
        s.imm    = ($urandom % 2) ? $urandom : 32'($urandom % 40);
        s.op     = 4'($urandom % 16);
        return s;
    endfunction

    // ---------------- reference model ----------------
    // Expected EX register contents, plus the pending multiply.
    logic        m_rw = 0, m_mr = 0, m_mw = 0;
    logic [4:0]  m_rd = 0;
    logic [31:0] m_data = 0, m_alu = 0;
    int          busy_left = 0;          // edges until the product retires
    logic [31:0] c_a, c_b, c_st;
    logic        c_rw, c_mr, c_mw;
    logic        last_stall;

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] rf);
        if (m_rw && !m_mr && m_rd != 0 && m_rd == r) return m_alu;
        if (MEMRegWrite && MEMRd != 0 && MEMRd == r) return MEMData;
        return rf;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        int sh;
        sa = a;
        sh = int'(b % 32);
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return ~(a | b);
            4'h6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h7: return (a < b) ? 32'd1 : 32'd0;
            4'h8: return a << sh;
            4'h9: return a >> sh;
            4'hA: return sa >>> sh;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic exp_stall();
        return Rst_n && ((busy_left == 0 && IDValid && IDALUOp == 4'hF) || busy_left > 1);
    endfunction

    task automatic model_clear();
        m_rw = 0; m_mr = 0; m_mw = 0; m_rd = 0; m_data = 0; m_alu = 0;
        busy_left = 0;
    endtask

    task automatic cmp_outputs(input string pfx);
        check({pfx, "_rw"},   {31'b0, EXRegWrite}, {31'b0, m_rw});
        check({pfx, "_mr"},   {31'b0, EXMemRead},  {31'b0, m_mr});
        check({pfx, "_mw"},   {31'b0, EXMemWrite}, {31'b0, m_mw});
        check({pfx, "_rd"},   {27'b0, EXRd},       {27'b0, m_rd});
        check({pfx, "_data"}, EXData,  m_data);
        check({pfx, "_alu"},  EXALUData, m_alu);
    endtask

    // One clock: check Stall mid-cycle, predict, clock, compare outputs.
    task automatic cycle();
        logic [31:0] fa, fb, ob;
        logic        n_rw, n_mr, n_mw;
        logic [4:0]  n_rd;
        logic [31:0] n_data, n_alu;
        @(negedge Clk);
        last_stall = Stall;
        check("stall", {31'b0, Stall}, {31'b0, exp_stall()});
        fa = fwd(IDRs, IDA);
        fb = fwd(IDRt, IDB);
        ob = IDALUSrc ? IDImm : fb;
        n_rw = 0; n_mr = 0; n_mw = 0; n_rd = 0; n_data = 0; n_alu = 0;
        if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                n_rw = c_rw; n_mr = c_mr; n_mw = c_mw; n_rd = IDRd;
                n_data = c_st; n_alu = c_a * c_b;
            end
        end else if (IDValid) begin
            if (IDALUOp == 4'hF) begin
                c_a = fa; c_b = ob; c_st = fb;
                c_rw = IDRegWrite; c_mr = IDMemRead; c_mw = IDMemWrite;
                busy_left = 32;
            end else begin
                n_rw = IDRegWrite; n_mr = IDMemRead; n_mw = IDMemWrite;
                n_rd = IDRd; n_data = fb; n_alu = ref_alu(IDALUOp, fa, ob);
            end
        end
        @(posedge Clk);
        #1;
        m_rw = n_rw; m_mr = n_mr; m_mw = n_mw; m_rd = n_rd;
        m_data = n_data; m_alu = n_alu;
        cmp_outputs("ex");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        id_t cur, saved, scr;
        int  sc, bc;

        // Reset state
        #1 Rst_n = 1'b0;
        #1;
        model_clear();
        cmp_outputs("reset");
        check("reset_stall", {31'b0, Stall}, 32'd0);
        @(posedge Clk); @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk); #1;

        // ADD 5+7 -> 12, Rd=3
        set_mem(0, 0, 0);
        cur = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd3, 32'd5, 32'd7, 32'd0, 4'h0};
        apply(cur); cycle();
        check("add_alu", EXALUData, 32'd12);
        check("add_rd", {27'b0, EXRd}, 32'd3);
        check("add_rw", {31'b0, EXRegWrite}, 32'd1);

        // Forward priority: EX Rd=4 value 9 beats MEM Rd=4 value 1
        cur = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd4, 32'd4, 32'd5, 32'd0, 4'h0};
        apply(cur); cycle();
        set_mem(1, 4, 32'd1);
        cur = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 5'd0, 5'd5, 32'd77, 32'd0, 32'd1, 4'h0};
        apply(cur); cycle();
        check("fwd_prio", EXALUData, 32'd10);

        // Load in EX is not forwarded; MEM value 6 is used
        set_mem(0, 0, 0);
        cur = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd4, 32'd100, 32'd0, 32'd3, 4'h0};
        apply(cur); cycle();
        set_mem(1, 4, 32'd6);
        cur = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 5'd0, 5'd6, 32'h55, 32'd0, 32'd0, 4'h3};
        apply(cur); cycle();
        check("load_supp", EXALUData, 32'd6);

        // SRA / SLT / SLTU
        set_mem(0, 0, 0);
        cur = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7, 32'h8000_0000, 32'd4, 32'd0, 4'hA};
        apply(cur); cycle();
        check("sra", EXALUData, 32'hF800_0000);
        cur = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'h6};
        apply(cur); cycle();
        check("slt", EXALUData, 32'd1);
        cur.op = 4'h7;
        apply(cur); cycle();
        check("sltu", EXALUData, 32'd0);

        // MUL FFFFFFFF * 3
        cur = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 4'h0};
        cur.valid = 1'b0;
        apply(cur); cycle();
        cur = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd9, 32'hFFFF_FFFF, 32'd3, 32'd0, 4'hF};
        apply(cur);
        sc = 0; bc = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (last_stall) sc++;
            if (EXRegWrite) break;
            if (!EXMemRead && !EXMemWrite && EXRd == 0 && EXData == 0 && EXALUData == 0) bc++;
        end
        check("mul_stall_cycles", 32'(sc), 32'd32);
        check("mul_bubbles", 32'(bc), 32'd32);
        check("mul_prod", EXALUData, 32'hFFFF_FFFD);
        check("mul_rd", {27'b0, EXRd}, 32'd9);

        // Reset while a MUL is at counter 10
        cur = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd8, 32'h1234_5678, 32'h9ABC_DEF1, 32'd0, 4'hF};
        apply(cur);
        for (int i = 0; i < 11; i++) cycle();
        Rst_n = 1'b0;
        #1;
        model_clear();
        cmp_outputs("rst_mid");
        check("rst_mid_stall", {31'b0, Stall}, 32'd0);
        cur.valid = 1'b0;
        apply(cur);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        cur = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd2, 32'd1, 32'd1, 32'd0, 4'h0};
        apply(cur); cycle();
        check("post_rst_add", EXALUData, 32'd2);

        // Randomized streams; ID inputs are scrambled while stalled in BUSY
        // and restored for the retiring edge.
        saved = cur;
        for (int k = 0; k < 500; k++) begin
            set_mem($urandom % 2, 5'($urandom % 8), $urandom);
            if (busy_left == 0) begin
                cur = rnd_id();
                saved = cur;
                apply(cur);
            end else if (busy_left > 1) begin
                scr = rnd_id();
                apply(scr);
            end else begin
                apply(saved);
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
